scalar_wb_stage: RTL and testbench

- Downstream neighbour of the scalar ALU; consumes its result and branch decision in the compute unit's scalar pipe.
- Accepts one executed instruction per cycle over a valid/ready handshake.
- Buffers register writes in a small in-order queue drained by the shared register-file write port, and offers a bypass lookup into that queue.
- Raises a registered redirect for taken branches, kills wrong-path instructions arriving in the following cycle, and counts retired instructions.

---
 rtl/scalar_wb_stage_if.sv | 43 ++++
 rtl/scalar_wb_stage.sv | 103 ++++++++++
 tb/tb_scalar_wb_stage.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/scalar_wb_stage_if.sv
// Bundle for the scalar write-back stage: ALU input, register-file write port,
// bypass lookup, branch redirect and retire counter.
interface scalar_wb_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic            in_we;
    logic [4:0]      in_rd;
    logic [XLEN-1:0] in_result;
    logic            in_is_branch;
    logic            in_branch_taken;
    logic [31:0]     in_target;

    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            rf_ready;

    logic [4:0]      byp_rs;
    logic            byp_hit;
    logic [XLEN-1:0] byp_data;

    logic            redirect_valid;
    logic [31:0]     redirect_pc;
    logic [31:0]     retired_cnt;

    // Environment side: drives the ALU result, register-file ready and bypass query.
    modport master (
        output in_valid, in_we, in_rd, in_result, in_is_branch, in_branch_taken, in_target,
        output rf_ready, byp_rs,
        input  in_ready, rf_we, rf_waddr, rf_wdata, byp_hit, byp_data,
        input  redirect_valid, redirect_pc, retired_cnt
    );

    // Stage side.
    modport slave (
        input  in_valid, in_we, in_rd, in_result, in_is_branch, in_branch_taken, in_target,
        input  rf_ready, byp_rs,
        output in_ready, rf_we, rf_waddr, rf_wdata, byp_hit, byp_data,
        output redirect_valid, redirect_pc, retired_cnt
    );
endinterface

// File: rtl/scalar_wb_stage.sv
// Scalar write-back stage: in-order register-write queue with bypass lookup,
// one-cycle branch redirect with wrong-path kill, and retired-instruction count.
module scalar_wb_stage #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned XLEN  = 32
) (
    input logic              clk,
    input logic              rst_n,
    scalar_wb_stage_if.slave bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [4:0]       q_rd   [DEPTH];
    logic [XLEN-1:0]  q_data [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic             redir_valid_q;
    logic [31:0]      redir_pc_q;
    logic [31:0]      retired_q;

    logic             ready_c;
    logic             accept_c;
    logic             live_c;
    logic             push_c;
    logic             pop_c;
    logic             taken_c;
    logic             byp_hit_c;
    logic [XLEN-1:0]  byp_data_c;

    // Handshake and queue control; the instruction right after a redirect is wrong-path.
    assign ready_c  = (count < CNT_W'(DEPTH));
    assign accept_c = bus.in_valid & ready_c;
    assign live_c   = accept_c & ~redir_valid_q;
    assign push_c   = live_c & bus.in_we & (bus.in_rd != 5'd0);
    assign pop_c    = (count != CNT_W'(0)) & bus.rf_ready;
    assign taken_c  = live_c & bus.in_is_branch & bus.in_branch_taken;

    assign bus.in_ready       = ready_c;
    assign bus.rf_we          = (count != CNT_W'(0));
    assign bus.rf_waddr       = q_rd[head];
    assign bus.rf_wdata       = q_data[head];
    assign bus.byp_hit        = byp_hit_c;
    assign bus.byp_data       = byp_data_c;
    assign bus.redirect_valid = redir_valid_q;
    assign bus.redirect_pc    = redir_pc_q;
    assign bus.retired_cnt    = retired_q;

    // Write queue storage and pointers; simultaneous push and pop keeps count steady.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q_rd[i]   <= 5'd0;
                q_data[i] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_c) begin
                q_rd[tail]   <= bus.in_rd;
                q_data[tail] <= bus.in_result;
                tail         <= PTR_W'(tail + PTR_W'(1));
            end
            if (pop_c) begin
                head <= PTR_W'(head + PTR_W'(1));
            end
            count <= CNT_W'(count + CNT_W'(push_c) - CNT_W'(pop_c));
        end
    end

    // Redirect pulse, held target PC and retire counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redir_valid_q <= 1'b0;
            redir_pc_q    <= 32'd0;
            retired_q     <= 32'd0;
        end else begin
            redir_valid_q <= taken_c;
            if (taken_c) begin
                redir_pc_q <= bus.in_target;
            end
            if (live_c) begin
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    // Bypass search from oldest to youngest so the youngest match wins.
    always_comb begin
        byp_hit_c  = 1'b0;
        byp_data_c = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if ((CNT_W'(k) < count) && (bus.byp_rs != 5'd0) &&
                (q_rd[PTR_W'(head + PTR_W'(k))] == bus.byp_rs)) begin
                byp_hit_c  = 1'b1;
                byp_data_c = q_data[PTR_W'(head + PTR_W'(k))];
            end
        end
    end
endmodule

// File: tb/tb_scalar_wb_stage.sv
// Directed bench for scalar_wb_stage with write and redirect scoreboards.
module tb_scalar_wb_stage;
    logic clk;
    logic rst_n;

    scalar_wb_stage_if #(.XLEN(32)) bus ();

    scalar_wb_stage #(.DEPTH(2), .XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned  nvec = 0;
    int unsigned  nerr = 0;
    logic [36:0]  exp_q [$];
    logic [31:0]  red_q [$];
    logic [31:0]  retired_m = 32'd0;
    logic         exp_kill = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write-port scoreboard: every popped head must be the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && bus.rf_we && bus.rf_ready) begin
            if (exp_q.size() == 0) begin
                nvec++;
                assert (exp_q.size() != 0) else begin
                    nerr++;
                    $error("FAIL wb_extra observed=x%0d/%0h expected=none", bus.rf_waddr, bus.rf_wdata);
                end
            end else begin
                check("wb_order", 64'({bus.rf_waddr, bus.rf_wdata}), 64'(exp_q.pop_front()));
            end
        end
    end

    // Redirect scoreboard: one pulse per expected taken branch.
    always @(negedge clk) begin
        if (rst_n && bus.redirect_valid) begin
            if (red_q.size() == 0) begin
                nvec++;
                assert (red_q.size() != 0) else begin
                    nerr++;
                    $error("FAIL redirect_extra observed=%0h expected=none", bus.redirect_pc);
                end
            end else begin
                check("redirect_pc", 64'(bus.redirect_pc), 64'(red_q.pop_front()));
            end
        end
    end

    task automatic idle();
        @(posedge clk);
        #1;
        exp_kill = 1'b0;
    endtask

    task automatic send(input logic we, input logic [4:0] rd, input logic [31:0] data,
                        input logic br, input logic tk, input logic [31:0] tgt);
        check("in_ready_send", 64'(bus.in_ready), 64'(1));
        bus.in_valid        = 1'b1;
        bus.in_we           = we;
        bus.in_rd           = rd;
        bus.in_result       = data;
        bus.in_is_branch    = br;
        bus.in_branch_taken = tk;
        bus.in_target       = tgt;
        if (!exp_kill) begin
            retired_m = retired_m + 32'd1;
            if (we && rd != 5'd0) exp_q.push_back({rd, data});
            if (br && tk) red_q.push_back(tgt);
        end
        exp_kill = !exp_kill && br && tk;
        @(posedge clk);
        #1;
        bus.in_valid        = 1'b0;
        bus.in_we           = 1'b0;
        bus.in_is_branch    = 1'b0;
        bus.in_branch_taken = 1'b0;
    endtask

    initial begin
        rst_n               = 1'b0;
        bus.in_valid        = 1'b0;
        bus.in_we           = 1'b0;
        bus.in_rd           = 5'd0;
        bus.in_result       = 32'd0;
        bus.in_is_branch    = 1'b0;
        bus.in_branch_taken = 1'b0;
        bus.in_target       = 32'd0;
        bus.rf_ready        = 1'b0;
        bus.byp_rs          = 5'd0;

        // Reset values
        #2;
        check("rst_rf_we", 64'(bus.rf_we), 64'(0));
        check("rst_rf_waddr", 64'(bus.rf_waddr), 64'(0));
        check("rst_rf_wdata", 64'(bus.rf_wdata), 64'(0));
        check("rst_redirect", 64'({bus.redirect_valid, bus.redirect_pc}), 64'(0));
        check("rst_retired", 64'(bus.retired_cnt), 64'(0));
        check("rst_byp", 64'({bus.byp_hit, bus.byp_data}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_rst", 64'(bus.in_ready), 64'(1));

        // Fill the queue with the register file stalled, then drain in order
        send(1'b1, 5'd5, 32'h11, 1'b0, 1'b0, 32'd0);
        send(1'b1, 5'd6, 32'h22, 1'b0, 1'b0, 32'd0);
        check("full_in_ready", 64'(bus.in_ready), 64'(0));
        bus.in_valid  = 1'b1;
        bus.in_we     = 1'b1;
        bus.in_rd     = 5'd9;
        bus.in_result = 32'h99;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_we    = 1'b0;
        check("full_no_accept", 64'(bus.retired_cnt), 64'(retired_m));
        bus.rf_ready = 1'b1;
        idle();
        check("ready_after_pop", 64'(bus.in_ready), 64'(1));
        idle();
        check("drained", 64'(bus.rf_we), 64'(0));

        // rd=0 write is retired but never queued
        send(1'b1, 5'd0, 32'hDEAD, 1'b0, 1'b0, 32'd0);
        check("rd0_no_we", 64'(bus.rf_we), 64'(0));
        check("rd0_retired", 64'(bus.retired_cnt), 64'(retired_m));

        // Taken branch kills the following instruction
        send(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 32'h100);
        check("br_redirect_valid", 64'(bus.redirect_valid), 64'(1));
        check("br_redirect_pc", 64'(bus.redirect_pc), 64'(32'h100));
        send(1'b1, 5'd7, 32'h55, 1'b0, 1'b0, 32'd0);
        check("br_pulse_end", 64'(bus.redirect_valid), 64'(0));
        check("br_pc_hold", 64'(bus.redirect_pc), 64'(32'h100));
        check("br_retired", 64'(bus.retired_cnt), 64'(retired_m));
        check("br_killed_no_we", 64'(bus.rf_we), 64'(0));

        // Not-taken branch with link writes but does not redirect
        send(1'b1, 5'd1, 32'h44, 1'b1, 1'b0, 32'h300);
        check("nt_no_redirect", 64'(bus.redirect_valid), 64'(0));
        check("nt_we", 64'({bus.rf_we, bus.rf_waddr, bus.rf_wdata}), 64'({1'b1, 5'd1, 32'h44}));
        idle();
        idle();

        // Bypass returns the youngest matching entry
        bus.rf_ready = 1'b0;
        send(1'b1, 5'd3, 32'hA, 1'b0, 1'b0, 32'd0);
        send(1'b1, 5'd3, 32'hB, 1'b0, 1'b0, 32'd0);
        bus.byp_rs = 5'd3;
        #1;
        check("byp_two", 64'({bus.byp_hit, bus.byp_data}), 64'({1'b1, 32'hB}));
        bus.byp_rs = 5'd0;
        #1;
        check("byp_x0", 64'({bus.byp_hit, bus.byp_data}), 64'(0));
        bus.byp_rs = 5'd5;
        #1;
        check("byp_miss", 64'({bus.byp_hit, bus.byp_data}), 64'(0));
        bus.byp_rs   = 5'd3;
        bus.rf_ready = 1'b1;
        #1;
        check("byp_popping", 64'({bus.byp_hit, bus.byp_data}), 64'({1'b1, 32'hB}));
        idle();
        bus.rf_ready = 1'b0;
        check("byp_one", 64'({bus.byp_hit, bus.byp_data}), 64'({1'b1, 32'hB}));
        bus.rf_ready = 1'b1;
        idle();
        check("byp_empty", 64'({bus.byp_hit, bus.byp_data}), 64'(0));
        bus.byp_rs = 5'd0;

        // Reset mid-stream discards queued writes and the pending redirect
        bus.rf_ready = 1'b0;
        send(1'b1, 5'd10, 32'h1010, 1'b0, 1'b0, 32'd0);
        send(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 32'h200);
        check("pre_rst_we", 64'(bus.rf_we), 64'(1));
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        red_q.delete();
        retired_m = 32'd0;
        exp_kill  = 1'b0;
        #1;
        check("mid_rst_we", 64'(bus.rf_we), 64'(0));
        check("mid_rst_retired", 64'(bus.retired_cnt), 64'(0));
        check("mid_rst_redirect", 64'(bus.redirect_valid), 64'(0));
        bus.rf_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", 64'(bus.in_ready), 64'(1));
        check("post_rst_we", 64'(bus.rf_we), 64'(0));
        send(1'b1, 5'd12, 32'h77, 1'b0, 1'b0, 32'd0);
        check("post_rst_retired", 64'(bus.retired_cnt), 64'(retired_m));
        idle();
        idle();
        idle();

        check("wb_all_seen", 64'(exp_q.size()), 64'(0));
        check("redirect_all_seen", 64'(red_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
